// File: rtl/keypad_debounce_encoder.sv
// keypad_debounce_encoder
//
// Turns NUM_KEYS raw, bouncing, asynchronous button levels into single-cycle
// key events carrying a 1-based key code. Each raw bit passes through a
// 2-flop synchroniser and a per-key debounce counter. A small FSM then
// accepts a press only when exactly one debounced key is down, and locks out
// whenever two or more keys are down at the same time.
//
// Optional feature: define KEYPAD_AUTOREPEAT_EN to compile in auto-repeat.
// With it, holding a key emits repeat events: the first comes REPEAT_DELAY
// cycles after the press event, and later ones come every REPEAT_PERIOD
// cycles. Without it, key_repeat is tied low and each press gives one event.
//
// Ports
//   clk        : sole clock, all state on rising edge
//   rst        : synchronous active-high reset
//   key_raw    : asynchronous key levels, bit i = key code i+1
//   key_valid  : one-cycle event pulse
//   key_value  : code of the last event, held between events
//   key_repeat : high with key_valid when the event is an auto-repeat
//   key_held   : level, exactly one debounced key pressed (PRESSED/REPEAT)
//   multi_key  : level, FSM in LOCKOUT
//   state_dbg  : current FSM state (IDLE=0, PRESSED=1, REPEAT=2, LOCKOUT=3)
//
// Handshake: key_valid is a pulse with no back-pressure. key_value and
// key_repeat are meaningful in the cycle key_valid is high. key_value then
// keeps its value until the next event.
module keypad_debounce_encoder #(
  parameter int NUM_KEYS      = 12,
  parameter int CODE_W        = 4,
  parameter int DEBOUNCE_CYC  = 250000,
  parameter int ACTIVE_LOW    = 0,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic                key_valid,
  output logic [CODE_W-1:0]   key_value,
  output logic                key_repeat,
  output logic                key_held,
  output logic                multi_key,
  output logic [1:0]          state_dbg
);

  // Elaboration-time parameter sanity checks.
  if (NUM_KEYS < 2 || NUM_KEYS > 16) begin : g_bad_num_keys
    $error("NUM_KEYS must be in 2..16");
  end
  if ((1 << CODE_W) <= NUM_KEYS) begin : g_bad_code_w
    $error("CODE_W too narrow for NUM_KEYS");
  end
  if (DEBOUNCE_CYC < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_timing
    $error("DEBOUNCE_CYC, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [NUM_KEYS-1:0] KEY_ONE = NUM_KEYS'(1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESSED = 2'd1;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [1:0] S_REPEAT  = 2'd2;
`endif
  localparam logic [1:0] S_LOCKOUT = 2'd3;

  logic [NUM_KEYS-1:0] key_in;
  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] deb;
  logic [CNT_W-1:0]    deb_cnt [NUM_KEYS];
  logic [1:0]          state;

  // Polarity is normalised before synchronisation, so reset value 0 means
  // "released" in both polarities.
  assign key_in = (ACTIVE_LOW != 0) ? ~key_raw : key_raw;

  // Synchroniser and per-key debounce. A key's counter counts cycles where
  // the synchronised level disagrees with the debounced level. On the
  // DEBOUNCE_CYC-th consecutive disagreeing cycle the debounced bit flips.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < NUM_KEYS; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_W'(DEBOUNCE_CYC - 1)) begin
          deb[i]     <= ~deb[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Classify the debounced vector: none, exactly one (with its code), or many.
  logic              none_set;
  logic              one_set;
  logic              multi_set;
  logic [CODE_W-1:0] one_code;

  always_comb begin
    none_set  = (deb == '0);
    one_set   = !none_set && ((deb & (deb - KEY_ONE)) == '0);
    multi_set = !none_set && !one_set;
    one_code  = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (deb[i]) one_code = CODE_W'(i + 1);
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  logic [REP_W-1:0] rep_cnt;
  logic             key_repeat_r;
  assign key_repeat = key_repeat_r;
`else
  assign key_repeat = 1'b0;
`endif

  // Event FSM. Outputs are registered together with the transition that
  // produces them. A multi-key condition takes priority over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      key_valid <= 1'b0;
      key_value <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
      key_repeat_r <= 1'b0;
      rep_cnt      <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      key_repeat_r <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (multi_set) begin
            state <= S_LOCKOUT;
          end else if (one_set) begin
            state     <= S_PRESSED;
            key_valid <= 1'b1;
            key_value <= one_code;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= '0;
`endif
          end
        end
        S_PRESSED: begin
          if (multi_set) begin
            state <= S_LOCKOUT;
          end else if (none_set) begin
            state <= S_IDLE;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (rep_cnt == REP_W'(REPEAT_DELAY - 1)) begin
            state        <= S_REPEAT;
            key_valid    <= 1'b1;
            key_repeat_r <= 1'b1;
            rep_cnt      <= '0;
          end else begin
            rep_cnt <= rep_cnt + REP_W'(1);
          end
`endif
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        S_REPEAT: begin
          if (multi_set) begin
            state <= S_LOCKOUT;
          end else if (none_set) begin
            state <= S_IDLE;
          end else if (rep_cnt == REP_W'(REPEAT_PERIOD - 1)) begin
            key_valid    <= 1'b1;
            key_repeat_r <= 1'b1;
            rep_cnt      <= '0;
          end else begin
            rep_cnt <= rep_cnt + REP_W'(1);
          end
        end
`endif
        S_LOCKOUT: begin
          // A single key left down is not an event; wait for all-released.
          if (none_set) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  assign key_held = (state == S_PRESSED) || (state == S_REPEAT);
`else
  assign key_held = (state == S_PRESSED);
`endif
  assign multi_key = (state == S_LOCKOUT);
  assign state_dbg = state;

endmodule
